// File: rtl/pspl_master_pkg.sv
// Shared PS/PL protocol definitions: command codes exchanged on ctrl_out/ctrl_in,
// master state encoding and small elaboration-time helpers.
package pspl_master_pkg;

  typedef enum logic [7:0] {
    CMD_IDLE       = 8'd0,
    CMD_CALC       = 8'd1,
    CMD_SCAN       = 8'd2,
    CMD_PRINT      = 8'd3,
    CMD_IDLE_SYNC  = 8'd5,
    CMD_CALC_SYNC  = 8'd6,
    CMD_SCAN_SYNC  = 8'd7,
    CMD_PRINT_SYNC = 8'd8
  } cmd_e;

  // ST_ERROR is only reachable when the watchdog is compiled in.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SCAN,
    ST_SCAN_PUT,
    ST_SYNC1,
    ST_CALC,
    ST_SYNC2,
    ST_PRINT,
    ST_PRINT_ACK,
    ST_SYNC3,
    ST_ERROR
  } state_e;

  // Command code each state presents to the PL side.
  function automatic cmd_e state_cmd(input state_e s);
    case (s)
      ST_SCAN:      return CMD_SCAN;
      ST_SCAN_PUT:  return CMD_SCAN_SYNC;
      ST_CALC:      return CMD_CALC;
      ST_PRINT:     return CMD_PRINT;
      ST_PRINT_ACK: return CMD_PRINT_SYNC;
      default:      return CMD_IDLE;
    endcase
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/pspl_watchdog.sv
// Wait-state watchdog: counts cycles spent in one state and flags expiry at
// TIMEOUT_CYCLES. Only instantiated when PSPL_MASTER_TIMEOUT_EN is defined.
module pspl_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Saturating cycle counter; a state change restarts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/pspl_master.sv
// PS-side master of the PS/PL command handshake: scans the tx buffer out word by
// word, triggers a calculation, then prints the result words back into rx_buffer.
// Optional watchdog abort: define PSPL_MASTER_TIMEOUT_EN.
module pspl_master
  import pspl_master_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_IN_WIDTH  = 16,
  parameter int BUFFER_OUT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [BUFFER_IN_WIDTH-1:0]  tx_buffer,
  output logic [BUFFER_OUT_WIDTH-1:0] rx_buffer,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [7:0]                  ctrl_out,
  input  logic [7:0]                  ctrl_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  input  logic [DATA_WIDTH-1:0]       data_in
);

  localparam int NWI    = ceil_div(BUFFER_IN_WIDTH, DATA_WIDTH);
  localparam int NWO    = ceil_div(BUFFER_OUT_WIDTH, DATA_WIDTH);
  localparam int NW_MAX = (NWI > NWO) ? NWI : NWO;
  localparam int KW     = (NW_MAX > 1) ? $clog2(NW_MAX) : 1;
  localparam int TXW    = NWI * DATA_WIDTH;

  if (DATA_WIDTH < 1 || BUFFER_IN_WIDTH < 1 || BUFFER_OUT_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("pspl_master: all widths and TIMEOUT_CYCLES must be at least 1");
  end

  state_e                      r_state, w_state_next;
  logic [7:0]                  r_cin;
  logic [DATA_WIDTH-1:0]       r_din;
  logic [BUFFER_IN_WIDTH-1:0]  r_tx;
  logic [TXW-1:0]              w_tx_ext;
  logic [KW-1:0]               r_k, w_k_next;
  logic [7:0]                  r_ctrl_out;
  logic [DATA_WIDTH-1:0]       r_data_out, w_data_next;
  logic [BUFFER_OUT_WIDTH-1:0] r_rx, w_rx_next;
  logic                        r_busy, r_done, w_done_next;
  logic                        w_tx_load, w_rx_write;
  logic                        w_unused_din;

  // Zero-extends a partial last tx word.
  assign w_tx_ext = TXW'(r_tx);

  // Upper din bits fall outside rx_buffer when the last word is partial.
  assign w_unused_din = ^r_din;

`ifdef PSPL_MASTER_TIMEOUT_EN
  logic r_error;
  logic w_wd_clear, w_wd_count, w_wd_expired;

  assign w_wd_clear = (w_state_next != r_state);
  assign w_wd_count = (r_state != ST_IDLE) && (r_state != ST_ERROR);

  pspl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (w_wd_clear),
    .i_count  (w_wd_count),
    .o_expired(w_wd_expired)
  );
`endif

  // Input stage: the PL echo and its data word are registered together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cin <= '0;
      r_din <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      r_cin <= ctrl_in;
      r_din <= data_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: each wait state advances only on its expected echo.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    w_state_next = r_state;
    w_k_next     = r_k;
    w_tx_load    = 1'b0;
    w_data_next  = r_data_out;
    w_rx_write   = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_tx_load    = 1'b1;
          w_k_next     = '0;
          w_state_next = ST_SYNC0;
        end
      end
      ST_SYNC0: if (r_cin == CMD_IDLE_SYNC) w_state_next = ST_SCAN;
      ST_SCAN: begin
        if (r_cin == CMD_SCAN) begin
          w_data_next  = w_tx_ext[int'(r_k) * DATA_WIDTH +: DATA_WIDTH];
          w_state_next = ST_SCAN_PUT;
        end
      end
      ST_SCAN_PUT: begin
        if (r_cin == CMD_SCAN_SYNC) begin
          if (r_k == KW'(NWI - 1)) begin
            w_state_next = ST_SYNC1;
          end else begin
            w_k_next     = r_k + 1'b1;
            w_state_next = ST_SCAN;
          end
        end
      end
      ST_SYNC1: if (r_cin == CMD_IDLE_SYNC) w_state_next = ST_CALC;
      ST_CALC:  if (r_cin == CMD_CALC_SYNC) w_state_next = ST_SYNC2;
      ST_SYNC2: begin
        if (r_cin == CMD_IDLE_SYNC) begin
          w_k_next     = '0;
          w_state_next = ST_PRINT;
        end
      end
      ST_PRINT: begin
        if (r_cin == CMD_PRINT) begin
          w_rx_write   = 1'b1;
          w_state_next = ST_PRINT_ACK;
        end
      end
      ST_PRINT_ACK: begin
        if (r_cin == CMD_PRINT_SYNC) begin
          if (r_k == KW'(NWO - 1)) begin
            w_state_next = ST_SYNC3;
          end else begin
            w_k_next     = r_k + 1'b1;
            w_state_next = ST_PRINT;
          end
        end
      end
      ST_SYNC3: begin
        if (r_cin == CMD_IDLE_SYNC) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
`ifdef PSPL_MASTER_TIMEOUT_EN
      ST_ERROR: begin
        if (start) begin
          w_tx_load    = 1'b1;
          w_k_next     = '0;
          w_state_next = ST_SYNC0;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
`ifdef PSPL_MASTER_TIMEOUT_EN
    // An expired wait overrides any handshake progress in the same cycle.
    if (w_wd_expired && w_wd_count) begin
      w_state_next = ST_ERROR;
      w_k_next     = r_k;
      w_rx_write   = 1'b0;
      w_done_next  = 1'b0;
      w_data_next  = r_data_out;
    end
`endif
  end

  // Place the captured word into rx slot k; bits past the buffer end are dropped.
  always_comb begin
    w_rx_next = r_rx;
    if (w_rx_write) begin
      for (int i = 0; i < BUFFER_OUT_WIDTH; i++) begin
        if (i / DATA_WIDTH == int'(r_k)) w_rx_next[i] = r_din[i % DATA_WIDTH];
      end
    end
  end

  // Datapath and output registers; outputs follow the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the rx buffer is a handful of flops, not a RAM, so it is reset
      // along with the rest of the outputs.
      r_k        <= '0;
      r_tx       <= '0;
      r_ctrl_out <= '0;
      r_data_out <= '0;
      r_rx       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_k        <= w_k_next;
      if (w_tx_load) r_tx <= tx_buffer;
      r_ctrl_out <= state_cmd(w_state_next);
      r_data_out <= w_data_next;
      r_rx       <= w_rx_next;
      r_busy     <= (w_state_next != ST_IDLE) && (w_state_next != ST_ERROR);
      r_done     <= w_done_next;
    end
  end

`ifdef PSPL_MASTER_TIMEOUT_EN
  // Error flag: raised on watchdog abort, cleared by the restarting start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     r_error <= 1'b0;
    else if (w_tx_load)               r_error <= 1'b0;
    else if (w_state_next == ST_ERROR) r_error <= 1'b1;
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign ctrl_out  = r_ctrl_out;
  assign data_out  = r_data_out;
  assign rx_buffer = r_rx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pspl_master.sv
// Self-checking bench for pspl_master: a behavioural PL-side responder echoes
// commands and returns buffer_in + 1; transactions use random tx buffers.
module tb_pspl_master;

  localparam int DW  = 8;
  localparam int BIW = 20;
  localparam int BOW = 20;
  localparam int TO  = 16;
  localparam int NWI = 3;   // ceil(20/8)
  localparam int NWO = 3;

  logic           clock;
  logic           reset_n;
  logic           start;
  logic [BIW-1:0] tx_buffer;
  logic [BOW-1:0] rx_buffer;
  logic           busy, done, error;
  logic [7:0]     ctrl_out, ctrl_in;
  logic [DW-1:0]  data_out, data_in;

  int errors = 0;
  int checks = 0;

  pspl_master #(
    .DATA_WIDTH(DW), .BUFFER_IN_WIDTH(BIW), .BUFFER_OUT_WIDTH(BOW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .tx_buffer(tx_buffer),
    .rx_buffer(rx_buffer), .busy(busy), .done(done), .error(error),
    .ctrl_out(ctrl_out), .ctrl_in(ctrl_in), .data_out(data_out), .data_in(data_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- PL-side responder ----------------
  bit          pl_stall;
  logic [7:0]  pl_prev;
  int          pl_si, pl_pi;
  logic [23:0] pl_buf_in, pl_buf_out;
  logic [7:0]  scan_q[$];

  always @(negedge clock) begin
    if (pl_stall) begin
      ctrl_in = 8'd0;
    end else begin
      case (ctrl_out)
        8'd0: ctrl_in = 8'd5;
        8'd2: begin
          ctrl_in = 8'd2;
          if (pl_prev == 8'd0) pl_si = 0;
        end
        8'd7: begin
          ctrl_in = 8'd7;
          if (pl_prev != 8'd7) begin
            scan_q.push_back(data_out);
            pl_buf_in[pl_si*8 +: 8] = data_out;
            pl_si++;
          end
        end
        8'd1: begin
          ctrl_in    = 8'd6;
          pl_buf_out = pl_buf_in + 24'd1;
          pl_pi      = 0;
        end
        8'd3: begin
          ctrl_in = 8'd3;
          data_in = pl_buf_out[pl_pi*8 +: 8];
          // junk above the buffer end must be discarded by the master
          if (pl_pi == NWO - 1) data_in = data_in | {4'($urandom), 4'h0};
        end
        8'd8: begin
          ctrl_in = 8'd8;
          if (pl_prev != 8'd8) pl_pi++;
        end
        default: ctrl_in = 8'd0;
      endcase
    end
    pl_prev = ctrl_out;
  end

  // ---------------- monitor ----------------
  logic [7:0] ctrl_q[$];
  logic [7:0] mon_last;
  int         done_cnt;

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && ctrl_out !== mon_last) begin
      ctrl_q.push_back(ctrl_out);
      mon_last = ctrl_out;
    end
  end

  task automatic clear_mon();
    ctrl_q.delete();
    scan_q.delete();
    mon_last = 8'hFF;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic pulse_start(input logic [BIW-1:0] tx);
    tx_buffer = tx;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    tx_buffer = BIW'($urandom);  // master must have latched its copy
  endtask

  // One full transaction checked against the protocol rules.
  task automatic run_txn(input logic [BIW-1:0] tx, input bit poke);
    logic [31:0] t, exp_rx, exp_w;
    logic [7:0]  exp_q[$];
    int          n, len;
    t      = 32'(tx);
    exp_rx = (t + 32'd1) & 32'h000F_FFFF;
    exp_q  = {8'd0};
    repeat (NWI) begin exp_q.push_back(8'd2); exp_q.push_back(8'd7); end
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    repeat (NWO) begin exp_q.push_back(8'd3); exp_q.push_back(8'd8); end
    exp_q.push_back(8'd0);

    clear_mon();
    pulse_start(tx);
    if (poke) begin
      n = 0;
      while (ctrl_out !== 8'd7 && n < 200) begin @(negedge clock); n++; end
      check("poke_reach_scan_put", 32'(ctrl_out), 32'd7);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done("txn_done");
    repeat (4) @(negedge clock);

    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("error_after", 32'(error), 32'd0);
    check("rx_buffer", 32'(rx_buffer), exp_rx);
    check("scan_words", 32'(scan_q.size()), 32'(NWI));
    for (int k = 0; k < NWI && k < scan_q.size(); k++) begin
      exp_w = (t >> (8 * k)) & 32'hFF;
      check($sformatf("scan_word%0d", k), 32'(scan_q[k]), exp_w);
    end
    check("ctrl_seq_len", 32'(ctrl_q.size()), 32'(exp_q.size()));
    len = (ctrl_q.size() < exp_q.size()) ? ctrl_q.size() : exp_q.size();
    for (int i = 0; i < len; i++)
      check($sformatf("ctrl_seq%0d", i), 32'(ctrl_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [BIW-1:0] a;
    logic [31:0]    e;
    int             n;
    reset_n   = 1'b0;
    start     = 1'b0;
    tx_buffer = '0;
    ctrl_in   = 8'd0;
    data_in   = '0;
    pl_stall  = 1'b0;
    pl_prev   = 8'd0;
    pl_si     = 0;
    pl_pi     = 0;
    pl_buf_in = '0;
    pl_buf_out = '0;
    clear_mon();

    repeat (3) @(negedge clock);
    check("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_rx", 32'(rx_buffer), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);

    // Boundary buffers, then random ones.
    run_txn(20'h00000, 1'b0);
    run_txn(20'hFFFFF, 1'b0);
    run_txn(20'hBEEF, 1'b0);
    repeat (5) run_txn(BIW'($urandom), 1'b0);

    // start while in SCAN_PUT is ignored.
    run_txn(BIW'($urandom), 1'b1);

    // start in the cycle after done is accepted.
    clear_mon();
    pulse_start(BIW'($urandom));
    wait_done("b2b_first_done");
    @(negedge clock);
    check("b2b_idle", 32'(busy), 32'd0);
    a = BIW'($urandom);
    clear_mon();
    pulse_start(a);
    check("b2b_accepted", 32'(busy), 32'd1);
    wait_done("b2b_second_done");
    e = (32'(a) + 32'd1) & 32'h000F_FFFF;
    check("b2b_rx", 32'(rx_buffer), e);

    // Asynchronous reset in PRINT_ACK, then a clean resynchronised transaction.
    repeat (2) @(negedge clock);
    clear_mon();
    pulse_start(BIW'($urandom));
    n = 0;
    while (ctrl_out !== 8'd8 && n < 500) begin @(negedge clock); n++; end
    check("reach_print_ack", 32'(ctrl_out), 32'd8);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ctrl_out", 32'(ctrl_out), 32'd0);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_rx", 32'(rx_buffer), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_txn(BIW'($urandom), 1'b0);

    // PL side silent: wait in SYNC0 forever, or abort when the watchdog exists.
    pl_stall = 1'b1;
    repeat (3) @(negedge clock);
    a = BIW'($urandom);
    clear_mon();
    pulse_start(a);
    repeat (40) @(negedge clock);
    check("stall_ctrl_out", 32'(ctrl_out), 32'd0);
`ifdef PSPL_MASTER_TIMEOUT_EN
    check("stall_error", 32'(error), 32'd1);
    check("stall_busy", 32'(busy), 32'd0);
    pl_stall = 1'b0;
    repeat (2) @(negedge clock);
    clear_mon();
    pulse_start(a);
    check("restart_error_clear", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
`else
    check("stall_error", 32'(error), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    pl_stall = 1'b0;
`endif
    wait_done("stall_done");
    e = (32'(a) + 32'd1) & 32'h000F_FFFF;
    check("stall_rx", 32'(rx_buffer), e);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
